hamming_dec_engine: RTL
=======================

# hamming_dec_engine

Autonomous SECDED (16,11) Hamming decoder: the receive-side counterpart of the program-1 parity encoder. On a start request it walks 15 two-byte codewords in data memory, computes syndrome and overall parity, corrects single-bit errors, flags double errors, and writes each 11-bit message plus a 2-bit status back to memory. It sits beside the core as a data-memory master sharing `dm1`'s single port, and raises `done` when finished.

## Interface
- `SRC_BASE`, 30: byte address of the first codeword; low byte at even address, high byte at address+1.
- `DST_BASE`, 0: byte address of the first decoded output pair; low byte first.
- `NUM_WORDS`, 15: codewords per run; must be 1..127.
- `AW`, 8: memory address width.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low; when low, all state clears immediately.
- `start`  in  1  single-cycle request; sampled only in IDLE or DONE.
- `done`  out  1  high in DONE until the next accepted `start`; reset value 0.
- `mem_addr`  out  AW  byte address; reset value 0.
- `mem_we`  out  1  write strobe, write committed at the rising edge; reset value 0.
- `mem_wdata`  out  8  write data; reset value 0.
- `mem_rdata`  in  8  asynchronous read data for `mem_addr`, valid in the same cycle.

## Operation
- Codeword layout, high to low, bits 15..0: d11..d5, p8, d4..d2, p4, d1, p2, p1, p0. Bit index k equals Hamming position k. p0 is the overall parity bit.
- Syndrome s[3:0] = XOR of indices k in 1..15 where cw[k]=1. Overall parity P = ^cw[15:0].
- s=0, P=0: no error, F=2'b00.
- s≠0, P=1: single error at position s; invert cw[s] before extraction; F=2'b01.
- s=0, P=1: error in p0 only; data is unaffected; F=2'b01.
- s≠0, P=0: double error; extract data uncorrected; F=2'b10.
- Output: high byte {F[1:0], 3'b000, d11..d9}; low byte d8..d1.
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE. The `ws` variable used below is defined as 2·word index.
- IDLE/DONE + start → RD_LO. Word index resets to 0 and `done` clears.
- RD_LO: `mem_addr` = SRC_BASE+ws; latch the low byte; go to RD_HI.
- RD_HI: `mem_addr` = SRC_BASE+ws+1; latch the high byte; go to WR_LO.
- WR_LO: `mem_addr` = DST_BASE+ws; `mem_we`=1; `mem_wdata` = low out byte; go to WR_HI.
- WR_HI: `mem_addr` = DST_BASE+ws+1; `mem_we`=1; `mem_wdata` = high out byte. Go to RD_LO for the next word, or to DONE after word NUM_WORDS-1.
- `start` while busy (RD_*/WR_*) is ignored, not queued.
- `start` in DONE restarts a full run.
- Address arithmetic is modulo 2^AW; wrap-around is not checked.
- Reset mid-run: return to IDLE with outputs at reset values. Words already written stay in memory; no partial write occurs.

## Timing
- 4 cycles per word. With `start` sampled at edge E0, word i reads in cycles 4i+1 and 4i+2 and writes at edges E(4i+3) and E(4i+4).
- `done` rises at edge E(4·NUM_WORDS), which is E60 for the default run. It stays high until reset or an accepted start.
- `mem_we` is high only in WR_LO and WR_HI.
- Decode is combinational from the latched bytes and is stable in both WR states.

## Structure
- Package `hamming_pkg`: the `dec_state_t` enum, the `dec_flag_t` enum (NO_ERR=2'b00, ONE_FIX=2'b01, TWO_ERR=2'b10), and the constants for the default SRC_BASE, DST_BASE and NUM_WORDS.
- Sub-module `secded_fix`: purely combinational. Takes cw[15:0] and produces the 11-bit data and F[1:0]. It is reusable by the encoder bench as a golden checker.
- The top contains the FSM, word counter, byte latches and memory mux.

## Test plan
- Codeword 16'h0000 → output 16'h0000 (F=00). 16'hFFFF → 16'h07FF (F=00).
- Codeword 16'h7FFF (bit 15 flipped from 16'hFFFF) → 16'h47FF. Codeword 16'h0008 → 16'h4000 (d1 corrected).
- Codeword 16'h0001 (p0 only) → 16'h4000. Codeword 16'h0003 (two errors) → 16'h8000.
- 15 random 11-bit messages encoded by the program-1 model, with random 0/1/2 bit flips → every output matches `secded_fix`. `done` rises exactly 60 cycles after start; SRC bytes 30..59 are unchanged.
- `start` pulsed at cycles 10 and 25 during a run → single run, `done` still at 60. `start` in DONE → second full run.
- `reset` low at cycle 21 → immediate IDLE, `done`=0 and `mem_we`=0. Only words 0..4 have been written; a later start completes normally.

Source files
------------

// File: rtl/hamming_dec_engine_pkg.sv
// hamming_pkg: shared types and default parameters for the SECDED (16,11)
// decoder engine.
//   dec_state_t : engine FSM states
//   dec_flag_t  : per-word decode status written into the high output byte
//   DEF_*       : default memory layout and run length
package hamming_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } dec_state_t;

  typedef enum logic [1:0] {
    NO_ERR  = 2'b00,
    ONE_FIX = 2'b01,
    TWO_ERR = 2'b10
  } dec_flag_t;

  localparam int DEF_SRC_BASE  = 30;
  localparam int DEF_DST_BASE  = 0;
  localparam int DEF_NUM_WORDS = 15;

endpackage

// File: rtl/hamming_dec_engine_if.sv
// hamming_dec_engine_if: control handshake plus the single-port data-memory
// bus shared with the core.
//   start     : single-cycle run request
//   done      : run complete, held until the next accepted start
//   mem_addr  : byte address
//   mem_we    : write strobe, committed at the rising edge
//   mem_wdata : write data
//   mem_rdata : asynchronous read data for mem_addr
// master = decoder engine, slave = memory / system side.
interface hamming_dec_engine_if #(
  parameter int AW = 8
);
  logic          start;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  modport master (
    input  start, mem_rdata,
    output done, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output start, mem_rdata,
    input  done, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/hamming_dec_engine_secded_fix.sv
// secded_fix: purely combinational SECDED (16,11) decode of one codeword.
//   cw   : codeword, bit k is Hamming position k, bit 0 is overall parity
//   data : 11-bit message d11..d1 (corrected when a single error is found)
//   flag : NO_ERR / ONE_FIX / TWO_ERR
module secded_fix
  import hamming_pkg::*;
(
  input  logic [15:0] cw,
  output logic [10:0] data,
  output dec_flag_t   flag
);

  logic [3:0]  syn;
  logic        par;
  logic [15:0] fixed;

  always_comb begin
    syn = '0;
    for (int k = 1; k < 16; k++) begin
      if (cw[k]) syn = syn ^ 4'(k);
    end
    par   = ^cw;
    fixed = cw;
    flag  = NO_ERR;
    if (syn != 4'd0 && par) begin
      fixed[syn] = ~cw[syn];
      flag       = ONE_FIX;
    end else if (syn == 4'd0 && par) begin
      // only p0 flipped; message bits are intact
      flag = ONE_FIX;
    end else if (syn != 4'd0) begin
      flag = TWO_ERR;
    end
    // data bits live at the non-power-of-two positions
    data = {fixed[15:9], fixed[7:5], fixed[3]};
  end

endmodule

// File: rtl/hamming_dec_engine.sv
// hamming_dec_engine: autonomous SECDED decoder acting as a data-memory
// master. On start it reads NUM_WORDS two-byte codewords from SRC_BASE,
// decodes each one and writes {flag, 3'b0, d11..d9} / d8..d1 to DST_BASE.
//   clk   : single clock
//   reset : asynchronous, active-low
//   bus   : start/done handshake and memory port (master side)
//
// state | meaning
// IDLE  | waiting for start after reset
// RD_LO | reading low codeword byte at SRC_BASE+ws
// RD_HI | reading high codeword byte at SRC_BASE+ws+1
// WR_LO | writing low output byte at DST_BASE+ws
// WR_HI | writing high output byte at DST_BASE+ws+1
// DONE  | run finished, done high, waiting for start
module hamming_dec_engine
  import hamming_pkg::*;
#(
  parameter int SRC_BASE  = DEF_SRC_BASE,
  parameter int DST_BASE  = DEF_DST_BASE,
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int AW        = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  hamming_dec_engine_if.master  bus
);

  localparam int            IDX_W  = 7;
  localparam logic [AW-1:0] SRC_A  = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST_A  = AW'(DST_BASE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  dec_state_t       state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [AW-1:0]    ws;
  logic             last;
  logic [7:0]       lo_byte, hi_byte;
  logic [10:0]      dec_data;
  dec_flag_t        dec_flag;
  logic [7:0]       out_lo, out_hi;

  assign ws   = AW'({idx, 1'b0});
  assign last = (idx == LAST_IDX);

  secded_fix u_fix (
    .cw   ({hi_byte, lo_byte}),
    .data (dec_data),
    .flag (dec_flag)
  );

  assign out_lo = dec_data[7:0];
  assign out_hi = {dec_flag, 3'b000, dec_data[10:8]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (bus.start) state_nxt = RD_LO;
      RD_LO:      state_nxt = RD_HI;
      RD_HI:      state_nxt = WR_LO;
      WR_LO:      state_nxt = WR_HI;
      WR_HI:      state_nxt = last ? DONE : RD_LO;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.done      = 1'b0;
    unique case (state)
      RD_LO: bus.mem_addr = SRC_A + ws;
      RD_HI: bus.mem_addr = SRC_A + ws + AW'(1);
      WR_LO: begin
        bus.mem_addr  = DST_A + ws;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = out_lo;
      end
      WR_HI: begin
        bus.mem_addr  = DST_A + ws + AW'(1);
        bus.mem_we    = 1'b1;
        bus.mem_wdata = out_hi;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // word index and codeword byte latches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx     <= '0;
      lo_byte <= '0;
      hi_byte <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: if (bus.start) idx <= '0;
        RD_LO:      lo_byte <= bus.mem_rdata;
        RD_HI:      hi_byte <= bus.mem_rdata;
        WR_HI:      if (!last) idx <= idx + IDX_W'(1);
        default:    ;
      endcase
    end
  end

endmodule
